// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 PRGA engine.
//   rc4_state_e       : engine FSM states, one per cycle of the 9-cycle byte loop
//   RC4_DATA_W        : default byte width
//   RC4_S_DEPTH       : S permutation depth for the default byte width
//   RC4_CHAR_LO/HI    : default inclusive plaintext range ('a'..'z')
//   RC4_SPACE         : the space character, optionally accepted by the check
package rc4_pkg;

  localparam int unsigned RC4_DATA_W  = 8;
  localparam int unsigned RC4_S_DEPTH = 2 ** RC4_DATA_W;

  localparam logic [7:0] RC4_CHAR_LO = 8'h61;
  localparam logic [7:0] RC4_CHAR_HI = 8'h7A;
  localparam logic [7:0] RC4_SPACE   = 8'h20;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_SI,
    ST_LAT_SI,
    ST_RD_SJ,
    ST_LAT_SJ,
    ST_WR_I,
    ST_WR_J,
    ST_RD_F,
    ST_LAT_F,
    ST_WR_DEC,
    ST_DONE
  } rc4_state_e;

endpackage

// File: rtl/rc4_char_check.sv
// Combinational plaintext plausibility check on one byte.
//   data_i : candidate plaintext byte
//   pass_o : 1 if the byte is in [CHAR_LO, CHAR_HI], or is a space with
//            ALLOW_SPACE set; always 1 when CHECK_EN is 0
module rc4_char_check
  import rc4_pkg::*;
#(
  parameter int unsigned        DATA_W      = RC4_DATA_W,
  parameter bit                 CHECK_EN    = 1'b1,
  parameter logic [DATA_W-1:0]  CHAR_LO     = DATA_W'(RC4_CHAR_LO),
  parameter logic [DATA_W-1:0]  CHAR_HI     = DATA_W'(RC4_CHAR_HI),
  parameter bit                 ALLOW_SPACE = 1'b1
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              pass_o
);

  localparam logic [DATA_W-1:0] SPACE_W = DATA_W'(RC4_SPACE);

  logic in_range;
  logic is_space;

  always_comb begin
    in_range = (data_i >= CHAR_LO) && (data_i <= CHAR_HI);
    is_space = ALLOW_SPACE && (data_i == SPACE_W);
    pass_o   = !CHECK_EN || in_range || is_space;
  end

endmodule

// File: rtl/rc4_prga_engine.sv
// RC4 PRGA keystream generator and decryptor.
// Runs over an S permutation already left in the shared single-port S RAM by
// the KSA, performs the full RC4 swap in place, XORs the keystream with the
// encrypted-message ROM and writes plaintext to the decrypted-message RAM.
// Each byte takes 9 cycles (one FSM state per cycle). With CHECK_EN set, a
// byte outside the plausible character set is still written, then the run
// ends early with key_valid = 0.
//   clk, reset          : clock, synchronous active-high reset
//   start               : begin a run (only sampled in IDLE)
//   busy, done          : run in progress / one-cycle end-of-run pulse
//   key_valid           : every byte of the last run passed the check
//   s_addr/wdata/wren   : S RAM port, s_rdata returns one cycle later
//   msg_addr/msg_rdata  : encrypted ROM, one-cycle read latency
//   dec_addr/wdata/wren : decrypted RAM write port
module rc4_prga_engine
  import rc4_pkg::*;
#(
  parameter int unsigned        MSG_DEP     = 32,
  parameter int unsigned        DATA_W      = RC4_DATA_W,
  parameter bit                 CHECK_EN    = 1'b1,
  parameter logic [DATA_W-1:0]  CHAR_LO     = DATA_W'(RC4_CHAR_LO),
  parameter logic [DATA_W-1:0]  CHAR_HI     = DATA_W'(RC4_CHAR_HI),
  parameter bit                 ALLOW_SPACE = 1'b1,
  localparam int unsigned       MA_W        = (MSG_DEP > 1) ? $clog2(MSG_DEP) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              key_valid,
  output logic [DATA_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s_wren,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [MA_W-1:0]   msg_addr,
  input  logic [DATA_W-1:0] msg_rdata,
  output logic [MA_W-1:0]   dec_addr,
  output logic [DATA_W-1:0] dec_wdata,
  output logic              dec_wren
);

  localparam logic [MA_W-1:0] K_LAST = MA_W'(MSG_DEP - 1);

  rc4_state_e        state_q, state_d;
  logic [DATA_W-1:0] i_q, i_d;
  logic [DATA_W-1:0] j_q, j_d;
  logic [MA_W-1:0]   k_q, k_d;
  logic [DATA_W-1:0] si_q, si_d;
  logic [DATA_W-1:0] sj_q, sj_d;
  logic [DATA_W-1:0] f_q, f_d;
  logic [DATA_W-1:0] enc_q, enc_d;
  logic              kv_q, kv_d;

  logic [DATA_W-1:0] dec_byte;
  logic              byte_pass;

  assign dec_byte = f_q ^ enc_q;

  rc4_char_check #(
    .DATA_W      (DATA_W),
    .CHECK_EN    (CHECK_EN),
    .CHAR_LO     (CHAR_LO),
    .CHAR_HI     (CHAR_HI),
    .ALLOW_SPACE (ALLOW_SPACE)
  ) u_char_check (
    .data_i (dec_byte),
    .pass_o (byte_pass)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      f_q     <= '0;
      enc_q   <= '0;
      kv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      f_q     <= f_d;
      enc_q   <= enc_d;
      kv_q    <= kv_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    si_d      = si_q;
    sj_d      = sj_q;
    f_d       = f_q;
    enc_d     = enc_q;
    kv_d      = kv_q;
    done      = 1'b0;
    s_addr    = '0;
    s_wdata   = '0;
    s_wren    = 1'b0;
    msg_addr  = '0;
    dec_addr  = '0;
    dec_wdata = '0;
    dec_wren  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          kv_d    = 1'b0;
          state_d = ST_RD_SI;
        end
      end
      ST_RD_SI: begin
        s_addr  = i_q + DATA_W'(1);
        i_d     = i_q + DATA_W'(1);
        state_d = ST_LAT_SI;
      end
      ST_LAT_SI: begin
        si_d    = s_rdata;
        j_d     = j_q + s_rdata;
        state_d = ST_RD_SJ;
      end
      ST_RD_SJ: begin
        s_addr  = j_q;
        state_d = ST_LAT_SJ;
      end
      ST_LAT_SJ: begin
        sj_d    = s_rdata;
        state_d = ST_WR_I;
      end
      ST_WR_I: begin
        s_addr  = i_q;
        s_wdata = sj_q;
        s_wren  = 1'b1;
        state_d = ST_WR_J;
      end
      ST_WR_J: begin
        s_addr  = j_q;
        s_wdata = si_q;
        s_wren  = 1'b1;
        state_d = ST_RD_F;
      end
      ST_RD_F: begin
        s_addr   = si_q + sj_q;
        msg_addr = k_q;
        state_d  = ST_LAT_F;
      end
      ST_LAT_F: begin
        f_d     = s_rdata;
        enc_d   = msg_rdata;
        state_d = ST_WR_DEC;
      end
      ST_WR_DEC: begin
        dec_addr  = k_q;
        dec_wdata = dec_byte;
        dec_wren  = 1'b1;
        // A failing byte ends the run, so reaching here with a pass on the
        // last byte means every byte passed.
        if (!byte_pass || (k_q == K_LAST)) begin
          kv_d    = byte_pass;
          state_d = ST_DONE;
        end else begin
          k_d     = k_q + MA_W'(1);
          state_d = ST_RD_SI;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign key_valid = kv_q;

endmodule

// File: tb/tb_rc4_prga_engine.sv
// Bench for rc4_prga_engine: three engine configurations share one clock,
// each with its own S RAM / encrypted ROM / decrypted RAM model. Expected
// plaintext, final S and run length come from a plain RC4 loop model.
module tb_rc4_prga_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start     [3];
  logic preload   [3];
  logic busy      [3];
  logic done      [3];
  logic kv        [3];
  logic s_wren    [3];
  logic dec_wren  [3];
  logic [7:0] s_addr    [3];
  logic [7:0] s_wdata   [3];
  logic [7:0] s_rdata   [3];
  logic [7:0] msg_rdata [3];
  logic [7:0] dec_wdata [3];
  logic [0:0] ma_a, da_a;
  logic [3:0] ma_b, da_b;
  logic [4:0] ma_c, da_c;
  logic [4:0] ma [3];
  logic [4:0] da [3];

  always_comb begin
    ma[0] = {4'd0, ma_a};
    da[0] = {4'd0, da_a};
    ma[1] = {1'b0, ma_b};
    da[1] = {1'b0, da_b};
    ma[2] = ma_c;
    da[2] = da_c;
  end

  rc4_prga_engine #(.MSG_DEP(2), .DATA_W(8), .CHECK_EN(1'b0), .CHAR_LO(8'h61),
                    .CHAR_HI(8'h7A), .ALLOW_SPACE(1'b1)) u_a (
    .clk(clk), .reset(reset), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .key_valid(kv[0]), .s_addr(s_addr[0]), .s_wdata(s_wdata[0]), .s_wren(s_wren[0]),
    .s_rdata(s_rdata[0]), .msg_addr(ma_a), .msg_rdata(msg_rdata[0]),
    .dec_addr(da_a), .dec_wdata(dec_wdata[0]), .dec_wren(dec_wren[0]));

  rc4_prga_engine #(.MSG_DEP(9), .DATA_W(8), .CHECK_EN(1'b0), .CHAR_LO(8'h61),
                    .CHAR_HI(8'h7A), .ALLOW_SPACE(1'b1)) u_b (
    .clk(clk), .reset(reset), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .key_valid(kv[1]), .s_addr(s_addr[1]), .s_wdata(s_wdata[1]), .s_wren(s_wren[1]),
    .s_rdata(s_rdata[1]), .msg_addr(ma_b), .msg_rdata(msg_rdata[1]),
    .dec_addr(da_b), .dec_wdata(dec_wdata[1]), .dec_wren(dec_wren[1]));

  rc4_prga_engine #(.MSG_DEP(32), .DATA_W(8), .CHECK_EN(1'b1), .CHAR_LO(8'h61),
                    .CHAR_HI(8'h7A), .ALLOW_SPACE(1'b1)) u_c (
    .clk(clk), .reset(reset), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .key_valid(kv[2]), .s_addr(s_addr[2]), .s_wdata(s_wdata[2]), .s_wren(s_wren[2]),
    .s_rdata(s_rdata[2]), .msg_addr(ma_c), .msg_rdata(msg_rdata[2]),
    .dec_addr(da_c), .dec_wdata(dec_wdata[2]), .dec_wren(dec_wren[2]));

  // Memory models; staging arrays are copied in on a preload pulse.
  logic [7:0] s_stage [3][256];
  logic [7:0] e_stage [3][32];
  logic [7:0] smem    [3][256];
  logic [7:0] emem    [3][32];
  logic [7:0] dmem    [3][32];
  int         s_wcnt  [3];
  int         d_wcnt  [3];

  always @(posedge clk) begin
    for (int n = 0; n < 3; n++) begin
      if (preload[n]) begin
        for (int a = 0; a < 256; a++) smem[n][a] <= s_stage[n][a];
        for (int a = 0; a < 32; a++) begin
          emem[n][a] <= e_stage[n][a];
          dmem[n][a] <= 8'h00;
        end
        s_wcnt[n] <= 0;
        d_wcnt[n] <= 0;
      end else begin
        if (s_wren[n]) begin
          smem[n][s_addr[n]] <= s_wdata[n];
          s_wcnt[n] <= s_wcnt[n] + 1;
        end
        if (dec_wren[n]) begin
          dmem[n][da[n]] <= dec_wdata[n];
          d_wcnt[n] <= d_wcnt[n] + 1;
        end
      end
      s_rdata[n]   <= smem[n][s_addr[n]];
      msg_rdata[n] <= emem[n][ma[n]];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Reference model: straight RC4 PRGA over a copy of the staged S.
  logic [7:0] m_s [256];
  logic [7:0] m_d [32];
  int         m_n;
  bit         m_kv;

  function automatic bit char_ok(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  task automatic model(input int n, input int dep, input bit chk);
    logic [7:0] i, j, si, sj, idx;
    for (int a = 0; a < 256; a++) m_s[a] = s_stage[n][a];
    i = 0; j = 0; m_n = 0; m_kv = 1'b1;
    for (int k = 0; k < dep; k++) begin
      i = i + 8'd1;
      si = m_s[i];
      j = j + si;
      sj = m_s[j];
      m_s[i] = sj;
      m_s[j] = si;
      idx = si + sj;
      m_d[k] = m_s[idx] ^ e_stage[n][k];
      m_n++;
      if (chk && !char_ok(m_d[k])) begin
        m_kv = 1'b0;
        break;
      end
    end
  endtask

  logic [7:0] ct [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [71:0] pt_str = "Plaintext";
  logic [23:0] key_str = "Key";

  // skind: 0 identity, 1 KSA("Key"), 2 random permutation
  // ekind: 0 zeros, 1 "Plaintext" ciphertext, 2 all 'a', 3 random chars
  //        (sometimes one bad byte), 4 random bytes
  task automatic setup(input int n, input int dep, input int skind, input int ekind);
    logic [7:0] t, j8, ks [32], pl;
    int r, bad_pos;
    for (int a = 0; a < 256; a++) s_stage[n][a] = 8'(a);
    if (skind == 1) begin
      j8 = 0;
      for (int a = 0; a < 256; a++) begin
        j8 = j8 + s_stage[n][a] + key_str[8*(2 - (a % 3)) +: 8];
        t = s_stage[n][a]; s_stage[n][a] = s_stage[n][j8]; s_stage[n][j8] = t;
      end
    end else if (skind == 2) begin
      for (int a = 255; a > 0; a--) begin
        r = $urandom_range(a, 0);
        t = s_stage[n][a]; s_stage[n][a] = s_stage[n][r]; s_stage[n][r] = t;
      end
    end
    for (int k = 0; k < 32; k++) e_stage[n][k] = 8'h00;
    model(n, dep, 1'b0);
    for (int k = 0; k < 32; k++) ks[k] = m_d[k];
    bad_pos = ($urandom_range(1, 0) == 1) ? int'($urandom_range(dep - 1, 0)) : -1;
    for (int k = 0; k < dep; k++) begin
      case (ekind)
        1: e_stage[n][k] = ct[k];
        2: e_stage[n][k] = ks[k] ^ 8'h61;
        3: begin
          pl = ($urandom_range(7, 0) == 0) ? 8'h20 : 8'(8'h61 + $urandom_range(25, 0));
          if (k == bad_pos) pl = ($urandom_range(1, 0) == 1) ? 8'h7B : 8'(8'h21 + $urandom_range(63, 0));
          e_stage[n][k] = ks[k] ^ pl;
        end
        4: e_stage[n][k] = 8'($urandom);
        default: e_stage[n][k] = 8'h00;
      endcase
    end
  endtask

  task automatic run(input int n, input int p1, input int p2, output int cyc, output bit busy_ok);
    @(negedge clk);
    check($sformatf("idle_before_start_u%0d", n), {busy[n], done[n]}, 0);
    preload[n] = 1'b1;
    start[n]   = 1'b1;
    @(negedge clk);
    preload[n] = 1'b0;
    start[n]   = 1'b0;
    cyc = 1;
    busy_ok = 1'b1;
    while (!done[n] && cyc < 1000) begin
      if (!busy[n]) busy_ok = 1'b0;
      start[n] = (cyc == p1) || (cyc == p2);
      @(negedge clk);
      cyc++;
    end
    start[n] = 1'b0;
    if (!busy[n]) busy_ok = 1'b0;
    if (!done[n]) begin
      $display("FAIL run_timeout_u%0d got=%0d want=done", n, cyc);
      cyc = -1;
    end
  endtask

  task automatic compare_run(input string tag, input int n, input int cyc, input bit busy_ok,
                             input int exp_cyc, input int exp_kv);
    int bad;
    check({tag, "_cycles"}, cyc, (exp_cyc >= 0) ? exp_cyc : 9 * m_n + 1);
    check({tag, "_key_valid"}, kv[n], (exp_kv >= 0) ? exp_kv : int'(m_kv));
    check({tag, "_busy"}, busy_ok, 1);
    check({tag, "_dec_writes"}, d_wcnt[n], m_n);
    check({tag, "_s_writes"}, s_wcnt[n], 2 * m_n);
    bad = 0;
    for (int k = 0; k < m_n; k++) if (dmem[n][k] !== m_d[k]) bad++;
    check({tag, "_dec_bytes_bad"}, bad, 0);
    bad = 0;
    for (int a = 0; a < 256; a++) if (smem[n][a] !== m_s[a]) bad++;
    check({tag, "_final_s_bad"}, bad, 0);
  endtask

  typedef struct {
    int inst; int dep; bit chk; int skind; int ekind; int exp_cyc; int exp_kv;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int cyc, bad;
    bit bok;
    string tag;

    vecs[0] = '{0,  2, 1'b0, 0, 0,  19,  1};
    vecs[1] = '{2, 32, 1'b1, 0, 0,  10,  0};
    vecs[2] = '{1,  9, 1'b0, 1, 1,  82,  1};
    vecs[3] = '{2, 32, 1'b1, 0, 2, 289,  1};
    vecs[4] = '{1,  9, 1'b0, 2, 4,  82,  1};
    vecs[5] = '{1,  9, 1'b0, 2, 3,  82,  1};
    vecs[6] = '{2, 32, 1'b1, 2, 3,  -1, -1};
    vecs[7] = '{2, 32, 1'b1, 2, 3,  -1, -1};
    vecs[8] = '{2, 32, 1'b1, 2, 3,  -1, -1};
    vecs[9] = '{0,  2, 1'b0, 2, 4,  19,  1};

    for (int n = 0; n < 3; n++) begin
      start[n] = 1'b0;
      preload[n] = 1'b0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs_u0", {busy[0], done[0], kv[0], s_wren[0], dec_wren[0], s_addr[0],
                            s_wdata[0], ma_a, da_a, dec_wdata[0]}, 0);
    check("reset_outs_u1", {busy[1], done[1], kv[1], s_wren[1], dec_wren[1], s_addr[1],
                            s_wdata[1], ma_b, da_b, dec_wdata[1]}, 0);
    check("reset_outs_u2", {busy[2], done[2], kv[2], s_wren[2], dec_wren[2], s_addr[2],
                            s_wdata[2], ma_c, da_c, dec_wdata[2]}, 0);
    reset = 1'b0;

    for (int v = 0; v < 10; v++) begin
      tag = $sformatf("v%0d", v);
      setup(vecs[v].inst, vecs[v].dep, vecs[v].skind, vecs[v].ekind);
      model(vecs[v].inst, vecs[v].dep, vecs[v].chk);
      run(vecs[v].inst, 0, 0, cyc, bok);
      compare_run(tag, vecs[v].inst, cyc, bok, vecs[v].exp_cyc, vecs[v].exp_kv);
      if (v == 0) begin
        check("ident_dec0", dmem[0][0], 8'h02);
        check("ident_dec1", dmem[0][1], 8'h05);
        check("ident_s2", smem[0][2], 8'h03);
        check("ident_s3", smem[0][3], 8'h02);
      end
      if (v == 1) check("abort_dec0", dmem[2][0], 8'h02);
      if (v == 2) begin
        bad = 0;
        for (int k = 0; k < 9; k++) if (dmem[1][k] !== pt_str[8*(8 - k) +: 8]) bad++;
        check("plaintext_bad", bad, 0);
      end
      if (v == 3) begin
        bad = 0;
        for (int k = 0; k < 32; k++) if (dmem[2][k] !== 8'h61) bad++;
        check("all_a_bad", bad, 0);
      end
    end

    // start pulses inside a run must not disturb it
    setup(2, 32, 0, 2);
    model(2, 32, 1'b1);
    run(2, 3, 50, cyc, bok);
    compare_run("start_pulse", 2, cyc, bok, 289, 1);

    // reset in cycle 20 of a run
    setup(2, 32, 0, 2);
    @(negedge clk);
    preload[2] = 1'b1;
    start[2]   = 1'b1;
    @(negedge clk);
    preload[2] = 1'b0;
    start[2]   = 1'b0;
    cyc = 1;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    reset = 1'b1;
    @(negedge clk);
    check("midrun_reset_outs", {busy[2], done[2], kv[2], s_wren[2], dec_wren[2], s_addr[2],
                                s_wdata[2], ma_c, da_c, dec_wdata[2]}, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("midrun_reset_idle", busy[2], 0);
    check("midrun_reset_s_writes", s_wcnt[2], 4);
    check("midrun_reset_dec_writes", d_wcnt[2], 2);
    model(2, 32, 1'b1);
    run(2, 0, 0, cyc, bok);
    compare_run("after_reset", 2, cyc, bok, 289, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rc4_prga_engine.md
# rc4_prga_engine

Parametrised RC4 keystream-and-decrypt engine: the PRGA stage of the key-search datapath. It runs after the KSA has left a permuted S in the shared S RAM. It performs the full RC4 swap on S through a single-port synchronous RAM interface, XORs the keystream with an encrypted-message ROM, and writes the plaintext to a decrypted-message RAM. An optional plaintext-character check aborts early on a bad byte and reports whether the candidate key is plausible.

## Interface
- MSG_DEP, 32: message length in bytes (≥1).
- DATA_W, 8: byte width; S depth is fixed at 2**DATA_W.
- CHECK_EN, 1: 1 enables the character check and early abort.
- CHAR_LO, 8'h61 / CHAR_HI, 8'h7A: inclusive valid plaintext range.
- ALLOW_SPACE, 1: 1 also accepts 8'h20.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  begin a run; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE inclusive.
- done  out  1  one-cycle pulse at the end of a run.
- key_valid  out  DATA_W?1:1 → 1  result of the last run; holds until the next start.
- s_addr  out  DATA_W  S RAM address.
- s_wdata  out  DATA_W  S RAM write data.
- s_wren  out  1  S RAM write enable.
- s_rdata  in  DATA_W  S RAM read data, 1-cycle latency.
- msg_addr  out  $clog2(MSG_DEP)  encrypted ROM address.
- msg_rdata  in  DATA_W  encrypted ROM data, 1-cycle latency.
- dec_addr  out  $clog2(MSG_DEP)  decrypted RAM address.
- dec_wdata  out  DATA_W  decrypted RAM write data.
- dec_wren  out  1  decrypted RAM write enable.

## Operation
- Per byte k = 0..MSG_DEP-1, all arithmetic is mod 2**DATA_W:
  - i = i+1
  - si = S[i]
  - j = j+si
  - sj = S[j]
  - S[i] = sj, then S[j] = si
  - f = S[si+sj]
  - dec[k] = f ^ enc[k]
- i, j and k are cleared to 0 when start is accepted, so the first S index is 1.
- FSM states and per-state actions:
  - IDLE: on start, go to RD_SI.
  - RD_SI: s_addr = i+1; register i ← i+1.
  - LAT_SI: capture si; j ← j+si.
  - RD_SJ: s_addr = j.
  - LAT_SJ: capture sj.
  - WR_I: s_addr = i, s_wdata = sj, s_wren = 1.
  - WR_J: s_addr = j, s_wdata = si, s_wren = 1.
  - RD_F: s_addr = si+sj, msg_addr = k.
  - LAT_F: capture f and enc.
  - WR_DEC: dec_addr = k, dec_wdata = f^enc, dec_wren = 1; evaluate the check.
  - DONE: done = 1; go to IDLE.
- Transition out of WR_DEC:
  - To DONE if the check fails or k == MSG_DEP-1.
  - Otherwise k ← k+1 and go to RD_SI.
- Check: a byte passes if it is within [CHAR_LO, CHAR_HI], or ALLOW_SPACE is set and it equals 8'h20.
  - With CHECK_EN=0 every byte passes.
  - key_valid is 1 only when all MSG_DEP bytes pass.
  - A failing byte is still written to dec RAM before the abort.
- When i == j, both writes hit the same address with the same value. No special handling is required.
- The engine mutates S. The caller must rerun the KSA before the next key.
- start while busy is ignored.

## Timing
- 9 cycles per byte.
- start sampled high at edge 0 → done high in cycle 9·MSG_DEP+1 on a full run, or 9·(n+1)+1 on an abort at byte n.
- The next start is accepted in the cycle after done.
- Reset values:
  - State = IDLE.
  - busy, done, key_valid, s_wren, dec_wren = 0.
  - All addresses, s_wdata and dec_wdata = 0.
  - i, j, k = 0.
- Reset mid-run returns to IDLE on the next edge, with no further writes. S is left partially swapped and is the caller's responsibility.
- Write enables are never high outside WR_I, WR_J and WR_DEC.

## Structure
- Package rc4_pkg holds:
  - The state enum.
  - Default DATA_W.
  - CHAR_LO, CHAR_HI and SPACE constants.
  - The S depth localparam.
- One sub-module, rc4_char_check: combinational pass/fail on one byte, parametrised like the top.

## Test plan
- Identity S (S[x]=x), enc all 0, CHECK_EN=0, MSG_DEP=2 → dec[0]=8'h02, dec[1]=8'h05; S[2]=3, S[3]=2 afterwards; done in cycle 19.
- Same stimulus with CHECK_EN=1 → abort after byte 0: exactly one dec write, done in cycle 10, key_valid=0.
- Bench KSA with key "Key", enc = BB F3 16 E8 D9 40 AF 0A D3, MSG_DEP=9, CHECK_EN=0 → dec = "Plaintext"; done in cycle 82.
- Identity S, enc[k] = f_k ^ 8'h61 (model-computed), CHECK_EN=1, MSG_DEP=32 → all dec = 'a', key_valid=1, done in cycle 289.
- start pulsed in cycles 3 and 50 of a run → ignored, run timing unchanged.
- reset asserted in cycle 20 → IDLE next edge, all outputs 0, no writes; a fresh start after reS-reload completes normally.
